// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the imem read address and the IF/ID register.
// States: BOOT | one settling cycle after reset; RUN | normal fetch; HALT | stopped on EBREAK
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o,
  output logic [31:0] flush_count_o
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    misalign_d  = 1'b0;

    if (redirect_i) begin
      pc_d        = {redirect_pc_i[31:2], 2'b00};
      instr_d     = NOP_INSTR;
      id_pc_d     = 32'd0;
      id_pc4_d    = 32'd0;
      valid_d     = 1'b0;
      flush_cnt_d = flush_cnt_q + 32'd1;
      state_d     = ST_RUN;
      misalign_d  = |redirect_pc_i[1:0];
    end else if (stall_i && (state_q != ST_BOOT)) begin
      // Everything holds; BOOT ignores stall so it always settles in one cycle.
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          instr_d     = imem_rdata_i;
          id_pc_d     = pc_q;
          id_pc4_d    = pc_plus4;
          valid_d     = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          if (imem_rdata_i == EBREAK_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
        ST_BOOT: begin
          instr_d  = NOP_INSTR;
          id_pc_d  = 32'd0;
          id_pc4_d = 32'd0;
          valid_d  = 1'b0;
          state_d  = ST_RUN;
        end
        ST_HALT: begin
          instr_d  = NOP_INSTR;
          id_pc_d  = 32'd0;
          id_pc4_d = 32'd0;
          valid_d  = 1'b0;
        end
        default: begin
          instr_d  = NOP_INSTR;
          id_pc_d  = 32'd0;
          id_pc4_d = 32'd0;
          valid_d  = 1'b0;
          state_d  = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = id_pc_q;
  assign if_id_pc4_o   = id_pc4_q;
  assign if_id_valid_o = valid_q;
  assign halted_o      = (state_q == ST_HALT);
  assign misalign_o    = misalign_q;
  assign fetch_count_o = fetch_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, stall, redirect, misalign, EBREAK halt, PC wrap, mid-run reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;
  logic [31:0] flush_count_o;

  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata_i = mem[imem_addr_o[7:2]];

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_valid_o (if_id_valid_o),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o),
    .fetch_count_o (fetch_count_o),
    .flush_count_o (flush_count_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid_o}, 32'd0);
    check_eq({tag, ".instr"}, if_id_instr_o, 32'h0000_0013);
    check_eq({tag, ".pc"},    if_id_pc_o,    32'd0);
    check_eq({tag, ".pc4"},   if_id_pc4_o,   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0093 + (i << 20);
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst.addr",  imem_addr_o, 32'd0);
    check_bubble("rst");
    check_eq("rst.halt",  {31'd0, halted_o}, 32'd0);
    check_eq("rst.mis",   {31'd0, misalign_o}, 32'd0);
    check_eq("rst.fcnt",  fetch_count_o, 32'd0);
    check_eq("rst.xcnt",  flush_count_o, 32'd0);
    rst = 1'b1;

    // Boot: stall asserted during BOOT is ignored
    stall_i = 1'b1;
    step();
    stall_i = 1'b0;
    check_bubble("boot1");
    check_eq("boot1.addr", imem_addr_o, 32'd0);
    step();
    check_eq("boot2.instr", if_id_instr_o, 32'h0000_0093);
    check_eq("boot2.valid", {31'd0, if_id_valid_o}, 32'd1);
    check_eq("boot2.pc",    if_id_pc_o,  32'd0);
    check_eq("boot2.pc4",   if_id_pc4_o, 32'd4);
    check_eq("boot2.addr",  imem_addr_o, 32'd4);
    check_eq("boot2.fcnt",  fetch_count_o, 32'd1);

    repeat (4) step();
    check_eq("run.addr", imem_addr_o, 32'h14);
    check_eq("run.pc",   if_id_pc_o,  32'h10);
    check_eq("run.fcnt", fetch_count_o, 32'd5);

    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("stall.addr", imem_addr_o, 32'h14);
      check_eq("stall.pc",   if_id_pc_o,  32'h10);
      check_eq("stall.fcnt", fetch_count_o, 32'd5);
    end
    stall_i = 1'b0;
    step();
    check_eq("unstall.pc",    if_id_pc_o, 32'h14);
    check_eq("unstall.instr", if_id_instr_o, 32'h0050_0093);
    check_eq("unstall.fcnt",  fetch_count_o, 32'd6);
    check_eq("unstall.addr",  imem_addr_o, 32'h18);

    // Redirect wins over a simultaneous stall
    redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
    step();
    redirect_i = 1'b0; stall_i = 1'b0;
    check_eq("redir.addr", imem_addr_o, 32'h40);
    check_bubble("redir");
    check_eq("redir.xcnt", flush_count_o, 32'd1);
    check_eq("redir.fcnt", fetch_count_o, 32'd6);
    check_eq("redir.mis",  {31'd0, misalign_o}, 32'd0);
    step();
    check_eq("redir2.pc",    if_id_pc_o, 32'h40);
    check_eq("redir2.valid", {31'd0, if_id_valid_o}, 32'd1);
    check_eq("redir2.instr", if_id_instr_o, 32'h0100_0093);
    check_eq("redir2.fcnt",  fetch_count_o, 32'd7);

    redirect_i = 1'b1; redirect_pc_i = 32'h42;
    step();
    redirect_i = 1'b0;
    check_eq("mis.addr", imem_addr_o, 32'h40);
    check_eq("mis.pulse", {31'd0, misalign_o}, 32'd1);
    check_eq("mis.xcnt", flush_count_o, 32'd2);
    step();
    check_eq("mis.clear", {31'd0, misalign_o}, 32'd0);
    check_eq("mis.pc",    if_id_pc_o, 32'h40);

    // EBREAK planted at 0x10
    mem[4] = 32'h0010_0073;
    redirect_i = 1'b1; redirect_pc_i = 32'h08;
    step();
    redirect_i = 1'b0;
    check_eq("eb.xcnt", flush_count_o, 32'd3);
    repeat (2) step();
    check_eq("eb.preaddr", imem_addr_o, 32'h10);
    check_eq("eb.prefcnt", fetch_count_o, 32'd10);
    step();
    check_eq("eb.instr", if_id_instr_o, 32'h0010_0073);
    check_eq("eb.valid", {31'd0, if_id_valid_o}, 32'd1);
    check_eq("eb.pc",    if_id_pc_o, 32'h10);
    check_eq("eb.halt",  {31'd0, halted_o}, 32'd1);
    check_eq("eb.addr",  imem_addr_o, 32'h10);
    check_eq("eb.fcnt",  fetch_count_o, 32'd11);
    for (int k = 0; k < 2; k++) begin
      step();
      check_bubble("halt");
      check_eq("halt.addr", imem_addr_o, 32'h10);
      check_eq("halt.fcnt", fetch_count_o, 32'd11);
      check_eq("halt.halt", {31'd0, halted_o}, 32'd1);
    end
    mem[4] = 32'h0040_0093;
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    step();
    redirect_i = 1'b0;
    check_eq("unhalt.halt", {31'd0, halted_o}, 32'd0);
    check_eq("unhalt.addr", imem_addr_o, 32'h0);
    check_eq("unhalt.xcnt", flush_count_o, 32'd4);
    step();
    check_eq("resume.instr", if_id_instr_o, 32'h0000_0093);
    check_eq("resume.pc",    if_id_pc_o, 32'h0);
    check_eq("resume.fcnt",  fetch_count_o, 32'd12);

    repeat (7) step();
    check_eq("pre.addr", imem_addr_o, 32'h20);

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    check_eq("arst.addr", imem_addr_o, 32'd0);
    check_eq("arst.valid", {31'd0, if_id_valid_o}, 32'd0);
    check_eq("arst.fcnt", fetch_count_o, 32'd0);
    check_eq("arst.xcnt", flush_count_o, 32'd0);
    check_eq("arst.halt", {31'd0, halted_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Redirect during BOOT, then PC wrap-around
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    check_eq("wrap.addr", imem_addr_o, 32'hFFFF_FFFC);
    check_eq("wrap.xcnt", flush_count_o, 32'd1);
    step();
    check_eq("wrap.pc",    if_id_pc_o,  32'hFFFF_FFFC);
    check_eq("wrap.pc4",   if_id_pc4_o, 32'd0);
    check_eq("wrap.instr", if_id_instr_o, 32'h03F0_0093);
    check_eq("wrap.naddr", imem_addr_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
